// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared types and constants for unified_mem_ctrl             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int BYTE_OFS_W = 3;
  localparam int WORD_BYTES = 8;

endpackage
`default_nettype wire

// File: rtl/unified_mem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unified_mem_ctrl_if : request/ready bus between core and memory       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface unified_mem_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              mem_read;
  logic              mem_write;
  logic [63:0]       adr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              mem_err;

  modport master (
    output mem_read, mem_write, adr, wdata,
    input  rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, adr, wdata,
    output rdata, mem_ready, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_array_sp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_array_sp : single-port synchronous RAM with registered read port  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_array_sp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 64
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [DEPTH_LOG2-1:0] idx,
  input  wire logic                  we,
  input  wire logic                  re,
  input  wire logic [DATA_W-1:0]     wdata,
  output logic      [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unified_mem_ctrl : unified I/D memory with wait states and a          |
// | four-phase request/ready handshake. Optional: MEM_PERF_CNT_EN adds    |
// | rd_cnt / wr_cnt access counters.                                      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 64
) (
  input  wire logic        clk,
  input  wire logic        rst,
`ifdef MEM_PERF_CNT_EN
  output logic      [31:0] rd_cnt,
  output logic      [31:0] wr_cnt,
`endif
  unified_mem_ctrl_if.slave bus
);

  localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]      LAST_CNT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [63:0]     ADR_LIMIT = 64'(WORD_BYTES) << DEPTH_LOG2;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  op_e                     op_q, op_d;
  logic                    err_q, err_d;
  logic                    ready_q, ready_d;
  logic                    merr_q, merr_d;

  logic                    w_req;
  logic                    w_live_err;
  op_e                     w_live_op;
  logic [DEPTH_LOG2-1:0]   w_live_idx;
  logic                    w_access;
  logic [DEPTH_LOG2-1:0]   w_sel_idx;
  logic [DATA_W-1:0]       w_sel_wdata;
  op_e                     w_sel_op;
  logic                    w_sel_err;
  logic                    w_ok;
  logic                    w_we;
  logic                    w_re;

  assign w_req      = bus.mem_read | bus.mem_write;
  assign w_live_err = (bus.adr[BYTE_OFS_W-1:0] != '0)
                    | (bus.adr >= ADR_LIMIT)
                    | (bus.mem_read & bus.mem_write);
  assign w_live_op  = bus.mem_write ? OP_WR : OP_RD;
  assign w_live_idx = bus.adr[DEPTH_LOG2+BYTE_OFS_W-1:BYTE_OFS_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    op_d     = op_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    merr_d   = 1'b0;
    w_access = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (w_req) begin
          idx_d   = w_live_idx;
          wdata_d = bus.wdata;
          op_d    = w_live_op;
          err_d   = w_live_err;
          if (ZERO_WAIT) begin
            w_access = 1'b1;
            ready_d  = 1'b1;
            merr_d   = w_live_err;
            state_d  = RESP;
          end else begin
            cnt_d   = 4'd0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          w_access = 1'b1;
          ready_d  = 1'b1;
          merr_d   = err_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = DONE;
      end
      DONE: begin
        // Four-phase: a request still held here is the old one, not a new one.
        if (!w_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the sampling edge itself,
  // so the live bus values feed the array instead of the latched copies.
  assign w_sel_idx   = (state_q == IDLE) ? w_live_idx : idx_q;
  assign w_sel_wdata = (state_q == IDLE) ? bus.wdata  : wdata_q;
  assign w_sel_op    = (state_q == IDLE) ? w_live_op  : op_q;
  assign w_sel_err   = (state_q == IDLE) ? w_live_err : err_q;

  assign w_ok = w_access & ~w_sel_err & ~rst;
  assign w_we = w_ok & (w_sel_op == OP_WR);
  assign w_re = w_ok & (w_sel_op == OP_RD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      merr_q  <= merr_d;
    end
  end

  mem_array_sp #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .idx   (w_sel_idx),
    .we    (w_we),
    .re    (w_re),
    .wdata (w_sel_wdata),
    .rdata (bus.rdata)
  );

  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = merr_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'd0, w_re};
    wr_cnt_d = wr_cnt_q + {31'd0, w_we};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unified_mem_ctrl : scoreboard bench, WAIT_CYCLES=2 and =0 copies   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_unified_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.DATA_W(64)) if0 ();
  unified_mem_ctrl_if #(.DATA_W(64)) if1 ();

`ifdef MEM_PERF_CNT_EN
  logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
`endif

  unified_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .DATA_W(64)) dut0 (
    .clk    (clk),
    .rst    (rst),
`ifdef MEM_PERF_CNT_EN
    .rd_cnt (rd_cnt0),
    .wr_cnt (wr_cnt0),
`endif
    .bus    (if0)
  );

  unified_mem_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .DATA_W(64)) dut1 (
    .clk    (clk),
    .rst    (rst),
`ifdef MEM_PERF_CNT_EN
    .rd_cnt (rd_cnt1),
    .wr_cnt (wr_cnt1),
`endif
    .bus    (if1)
  );

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pc0    = 0;
  int   pc1    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (if0.mem_ready === 1'b1) begin
      pc0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready0 actual=1 expected=0 t=%0t", $time);
      end else begin
        e = q0.pop_front();
        chk("err0", {63'd0, if0.mem_err}, {63'd0, e.err});
        chk("rdata0", if0.rdata, e.rdata);
        chk("latency0", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.mem_ready === 1'b1) begin
      pc1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready1 actual=1 expected=0 t=%0t", $time);
      end else begin
        e = q1.pop_front();
        chk("err1", {63'd0, if1.mem_err}, {63'd0, e.err});
        chk("rdata1", if1.rdata, e.rdata);
        chk("latency1", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_req(int d, bit rd, bit wr, logic [63:0] a, logic [63:0] wd);
    if (d == 0) begin
      if0.mem_read  = rd;
      if0.mem_write = wr;
      if0.adr       = a;
      if0.wdata     = wd;
    end else begin
      if1.mem_read  = rd;
      if1.mem_write = wr;
      if1.adr       = a;
      if1.wdata     = wd;
    end
  endtask

  // Request raised now is sampled at the next edge; ready follows WAIT_CYCLES later.
  task automatic push(int d, bit err, logic [63:0] rd);
    exp_t e;
    e.err   = err;
    e.rdata = rd;
    e.cyc   = cyc + 1 + ((d == 0) ? 2 : 0);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_ready(int d, string name);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (((d == 0) ? if0.mem_ready : if1.mem_ready) === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s actual=no_ready expected=ready", name);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic xact(int d, bit rd, bit wr, logic [63:0] a, logic [63:0] wd,
                      bit exp_err, logic [63:0] exp_rd, string name);
    set_req(d, rd, wr, a, wd);
    push(d, exp_err, exp_rd);
    wait_ready(d, name);
    set_req(d, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_req(1, 1'b0, 1'b0, 64'd0, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready0", {63'd0, if0.mem_ready}, 64'd0);
    chk("rst_err0",   {63'd0, if0.mem_err},   64'd0);
    chk("rst_rdata0", if0.rdata,              64'd0);
    chk("rst_ready1", {63'd0, if1.mem_ready}, 64'd0);
    chk("rst_rdata1", if1.rdata,              64'd0);
    rst = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=2 copy
    xact(0, 0, 1, 64'h0,    64'h0A0A0A0A_0A0A0A0A, 0, 64'h0,                  "wr_w0");
    xact(0, 0, 1, 64'h40,   64'hDEADBEEF_CAFEF00D, 0, 64'h0,                  "wr_40");
    xact(0, 1, 0, 64'h40,   64'h0,                 0, 64'hDEADBEEF_CAFEF00D,  "rd_40");
    xact(0, 0, 1, 64'h8,    64'h11112222_33334444, 0, 64'hDEADBEEF_CAFEF00D,  "wr_8");

    // Held read: one pulse only, then a new request right after IDLE returns.
    p = pc0;
    set_req(0, 1, 0, 64'h8, 64'h0);
    push(0, 0, 64'h11112222_33334444);
    repeat (10) @(negedge clk);
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("held_pulses", 64'(pc0 - p), 64'd1);
    xact(0, 1, 0, 64'h40,   64'h0,                 0, 64'hDEADBEEF_CAFEF00D,  "rd_after_held");

    xact(0, 1, 0, 64'h44,   64'h0,                 1, 64'hDEADBEEF_CAFEF00D,  "rd_misalign");
    xact(0, 0, 1, 64'h2000, 64'h5555,              1, 64'hDEADBEEF_CAFEF00D,  "wr_range");
    xact(0, 1, 0, 64'h0,    64'h0,                 0, 64'h0A0A0A0A_0A0A0A0A,  "rd_w0");
    xact(0, 1, 1, 64'h40,   64'h9999,              1, 64'h0A0A0A0A_0A0A0A0A,  "both");
    xact(0, 1, 0, 64'h40,   64'h0,                 0, 64'hDEADBEEF_CAFEF00D,  "rd_40_again");
    xact(0, 0, 1, 64'h1FF8, 64'hFEED,              0, 64'hDEADBEEF_CAFEF00D,  "wr_top");
    xact(0, 1, 0, 64'h1FF8, 64'h0,                 0, 64'hFEED,               "rd_top");
    xact(0, 0, 1, 64'h10,   64'h1,                 0, 64'hFEED,               "wr_10");

    // Reset while a write to 0x10 sits in WAIT: the write must be dropped.
    set_req(0, 0, 1, 64'h10, 64'hBAD);
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("midrst_ready", {63'd0, if0.mem_ready}, 64'd0);
    chk("midrst_rdata", if0.rdata,              64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", {63'd0, if0.mem_ready}, 64'd0);
    xact(0, 1, 0, 64'h10,   64'h0,                 0, 64'h1,                  "rd_10");
    xact(0, 0, 1, 64'h18,   64'hABCD,              0, 64'h1,                  "wr_18");
    xact(0, 1, 0, 64'h18,   64'h0,                 0, 64'hABCD,               "rd_18");

    // WAIT_CYCLES=0 copy
    xact(1, 0, 1, 64'h20,   64'h77,                0, 64'h0,                  "z_wr_20");
    xact(1, 0, 1, 64'h28,   64'h88,                0, 64'h0,                  "z_wr_28");
    xact(1, 1, 0, 64'h20,   64'h0,                 0, 64'h77,                 "z_rd_20");
    xact(1, 1, 0, 64'h28,   64'h0,                 0, 64'h88,                 "z_rd_28");
    xact(1, 1, 0, 64'h20,   64'h0,                 0, 64'h77,                 "z_rd_20b");
`ifdef MEM_PERF_CNT_EN
    chk("rd_cnt", 64'(rd_cnt1), 64'd3);
    chk("wr_cnt", 64'(wr_cnt1), 64'd2);
`endif
    xact(1, 1, 0, 64'h21,   64'h0,                 1, 64'h77,                 "z_rd_misalign");
`ifdef MEM_PERF_CNT_EN
    chk("rd_cnt_err", 64'(rd_cnt1), 64'd3);
    chk("wr_cnt_err", 64'(wr_cnt1), 64'd2);
`endif

    repeat (3) @(negedge clk);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Unified instruction/data memory with controller, directly downstream of the RISC-V multi-cycle core.
- Consumes the core's inst_adr, dataOUT, MemRead and MemWrite; produces the core's dataIN.
- Adds a configurable wait-state model and a four-phase request/ready handshake so the core controller can be exercised against non-ideal memory latency.
- Holds one 64-bit word array shared by instruction fetch and load/store.

Parameters:
- DEPTH_LOG2, 10: log2 of word count; array has 2**DEPTH_LOG2 64-bit words.
- WAIT_CYCLES, 2: wait states inserted before each access; 0..15 legal.
- DATA_W, 64: data width; fixed at 64, byte address granularity 8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  read request (core MemRead); level, held until ready.
- mem_write  in  1  write request (core MemWrite); level, held until ready.
- adr  in  64  byte address (core inst_adr).
- wdata  in  64  write data (core dataOUT).
- rdata  out  64  read data (core dataIN); registered.
- mem_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  qualifies mem_ready; request rejected.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rdata=0, mem_ready=0, mem_err=0, state=IDLE, wait counter=0. Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP, DONE.
- IDLE:
  - On an edge with mem_read|mem_write=1, latch adr, wdata and op.
  - Go to WAIT with cnt=0, or directly to RESP (performing the access) if WAIT_CYCLES=0.
- WAIT:
  - cnt increments each edge.
  - On the edge where cnt==WAIT_CYCLES-1, perform the access and go to RESP.
- RESP:
  - mem_ready=1 for exactly this one cycle; mem_err per the rules below.
  - Next edge goes to DONE.
- DONE:
  - Stay until mem_read=0 and mem_write=0 are sampled, then go to IDLE (four-phase handshake).
  - A request held high never causes a second access.
- Latency: request sampled at edge k gives mem_ready high in the cycle after edge k+WAIT_CYCLES.
- Access rules:
  - Word index = latched adr[DEPTH_LOG2+2:3].
  - Read: rdata <= array[index].
  - Write: array[index] <= wdata; rdata unchanged.
  - rdata holds its value until the next successful read or reset.
- Error (mem_err=1 with mem_ready) when any of:
  - adr[2:0]!=0 (misaligned);
  - adr >= 8*2**DEPTH_LOG2 (out of range);
  - mem_read and mem_write both 1 at sampling.
  On error: no array write, rdata unchanged, handshake proceeds normally.
- Input changes after sampling are ignored; latched values are used.
- Reset mid-operation (WAIT/RESP/DONE): return to IDLE, outputs go to reset values. A write not yet performed is dropped; a write already performed is kept.
- Read-after-write to the same word in back-to-back transactions returns the new data.

Optional Feature:
- Macro: MEM_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_cnt [31:0] and wr_cnt [31:0], each reset to 0.
  - Each increments by 1 on the edge entering RESP for a successful read/write; errored transactions do not count.
  - Counters wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counter logic absent; all other behaviour is identical.

Decomposition:
- Shared package (mem_pkg):
  - state encoding typedef (IDLE=0, WAIT=1, RESP=2, DONE=3);
  - op enum (OP_RD, OP_WR);
  - constants BYTE_OFS_W=3, WORD_BYTES=8.
- One sub-module: mem_array_sp. Single-port synchronous 64-bit RAM with index, we, wdata and registered read enable. The controller FSM stays in unified_mem_ctrl.

Test Plan:
- Write/read with WAIT_CYCLES=2: write 0xDEADBEEF_CAFEF00D to adr 0x40, then read adr 0x40 -> mem_ready 3 cycles after the sampling edge, mem_err=0, rdata=0xDEADBEEF_CAFEF00D.
- Held request: mem_read held high 10 cycles on adr 0x8 -> exactly one mem_ready pulse. After mem_read drops, the next request is accepted only once the FSM is back in IDLE.
- Errors:
  - Read adr 0x44 -> mem_ready with mem_err=1, rdata unchanged.
  - Write to adr 0x2000 with DEPTH_LOG2=10 -> mem_err=1; array word 0 unchanged.
- Both requests: mem_read=mem_write=1 -> mem_err=1, no array modification.
- Reset during WAIT of a write to 0x10 (old value 0x1) -> rst for one cycle, then a read of 0x10 returns 0x1; mem_ready=0 throughout reset.
- WAIT_CYCLES=0 with MEM_PERF_CNT_EN defined:
  - 3 reads and 2 writes -> each mem_ready one cycle after its sampling edge;
  - rd_cnt=3, wr_cnt=2 at end;
  - an added misaligned read leaves rd_cnt=3.
